iob_sync_pack_fifo: RTL
=======================

// Module: iob_sync_pack_fifo
// PURPOSE
//  Synchronous narrow-write / wide-read FIFO: packs RATIO narrow input words into one wide word.
//  Counterpart of the wide-write / narrow-read assim FIFO; feeds wide consumers (DMA, bus masters)
//  from byte/halfword producers. Single clock domain. Storage is a register array of wide words.
// PARAMETERS
//  W_DATA_W  8   write (narrow) data width
//  R_DATA_W  32  read (wide) data width; R_DATA_W = RATIO*W_DATA_W, RATIO power of two >= 2
//  R_ADDR_W  4   wide-word address width; storage DEPTH = 2**R_ADDR_W wide words
// PORTS
//  clk       in   1                       clock
//  rst       in   1                       reset, asynchronous, active-high
//  data_in   in   W_DATA_W                narrow write data
//  write_en  in   1                       write request
//  full      out  1                       write would be dropped
//  data_out  out  R_DATA_W                wide read data, registered
//  read_en   in   1                       read request
//  empty     out  1                       no complete wide word stored
//  level     out  R_ADDR_W+$clog2(RATIO)+1 occupancy in narrow words (stored*RATIO + lane)
//  flush     in   1                       (only with IOB_PACK_FIFO_FLUSH_EN) push partial word
// BEHAVIOUR
//  - Reset: lane=0, wptr=rptr=0, occ=0, data_out=0, empty=1, full=0, level=0. Array not reset.
//  - write_int = write_en & ~full; read_int = read_en & ~empty.
//  - Packing little-endian: k-th accepted narrow word (k=0..RATIO-1) lands in bits [k*W+:W].
//  - write_int with lane<RATIO-1: data_in stored in lane register, lane++.
//  - write_int with lane==RATIO-1: wide word {data_in, lanes RATIO-2..0} written to mem[wptr],
//    wptr++, lane=0 ("push"). Pointers wrap modulo DEPTH.
//  - full = (occ==DEPTH) & (lane==RATIO-1): lanes keep filling while storage full, only the
//    completing write is blocked. full ignores a same-cycle read (no write-through on pop).
//  - empty = (occ==0). Partial word in lane register is never visible to the reader.
//  - read_int: data_out <= mem[rptr] on the clock edge, rptr++; 1-cycle latency; data_out holds
//    its value when no read_int.
//  - occ: push&pop same cycle -> unchanged; push only -> +1; pop only -> -1. occ width R_ADDR_W+1.
//  - Write to empty FIFO completing a word and read same cycle: read ignored (empty registered view);
//    word readable next cycle.
//  - Dropped writes/reads (full/empty) change no state. Reset mid-operation discards all data.
// CONFIGURATION
//  - IOB_PACK_FIFO_FLUSH_EN defined: port flush present. flush & lane>0 & occ<DEPTH pushes the
//    partial word, unused upper lanes zero. flush with write_int same cycle: data_in placed in
//    current lane first, then pushed (upper lanes zero); if that write completes the word it is a
//    normal push. flush with lane==0 and no write: no-op. flush while occ==DEPTH: ignored, lanes kept.
//  - Not defined: no flush port; partial words wait until RATIO writes complete them.
// STRUCTURE
//  - Package iob_pack_fifo_pkg: RATIO, LANE_W=$clog2(RATIO), DEPTH, LEVEL_W; elaboration check
//    R_DATA_W%W_DATA_W==0 and RATIO power of two.
//  - Sub-module iob_pack_lane_reg: lane counter + RATIO-1 lane registers, outputs push strobe and
//    assembled wide word (also flush merge). Top holds pointers, occupancy, array, data_out.
// TESTING
//  - Reset, then write 0x11,0x22,0x33,0x44 -> empty falls after 4th write, level 4; read ->
//    data_out=0x44332211 next cycle, empty=1.
//  - Write 16*4+3=67 bytes (DEPTH=16) -> full=1 at lane 3 with occ 16; 68th write dropped, level 67.
//  - Full state, read and write same cycle -> write dropped, occ 15; next write accepted, full=0 then.
//  - Continuous write+read for 200 words across pointer wrap -> output sequence equals scoreboard,
//    no gap or duplicate.
//  - Read while empty and rst pulse mid-stream -> data_out unchanged / all outputs to reset values.
//  - FLUSH_EN: write 0xAA,0xBB then flush -> read gives 0x0000BBAA; flush with lane 0 -> no push.

Source files
------------

// File: rtl/iob_sync_pack_fifo_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iob_pack_fifo_pkg : shared constants and helpers for the packing FIFO
// Rev 1.0
// ----------------------------------------------------------------------------
package iob_pack_fifo_pkg;

  localparam int W_DATA_W_DEF = 8;
  localparam int R_DATA_W_DEF = 32;
  localparam int R_ADDR_W_DEF = 4;

  localparam int RATIO   = R_DATA_W_DEF / W_DATA_W_DEF;
  localparam int LANE_W  = $clog2(RATIO);
  localparam int DEPTH   = 2 ** R_ADDR_W_DEF;
  localparam int LEVEL_W = R_ADDR_W_DEF + LANE_W + 1;

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/iob_sync_pack_fifo_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iob_sync_pack_fifo_if : producer/consumer bus of the packing FIFO
// Optional flush signal with IOB_PACK_FIFO_FLUSH_EN.  Rev 1.0
// ----------------------------------------------------------------------------
interface iob_sync_pack_fifo_if
  import iob_pack_fifo_pkg::*;
#(
  parameter int W_DATA_W = W_DATA_W_DEF,
  parameter int R_DATA_W = R_DATA_W_DEF,
  parameter int R_ADDR_W = R_ADDR_W_DEF
);

  localparam int LVL_W = R_ADDR_W + $clog2(R_DATA_W / W_DATA_W) + 1;

  logic [W_DATA_W-1:0] data_in;
  logic                write_en;
  logic                full;
  logic [R_DATA_W-1:0] data_out;
  logic                read_en;
  logic                empty;
  logic [LVL_W-1:0]    level;
`ifdef IOB_PACK_FIFO_FLUSH_EN
  logic                flush;
`endif

  modport master (
    output data_in,
    output write_en,
    output read_en,
    input  full,
    input  data_out,
    input  empty,
    input  level
`ifdef IOB_PACK_FIFO_FLUSH_EN
    , output flush
`endif
  );

  modport slave (
    input  data_in,
    input  write_en,
    input  read_en,
    output full,
    output data_out,
    output empty,
    output level
`ifdef IOB_PACK_FIFO_FLUSH_EN
    , input flush
`endif
  );

endinterface
`default_nettype wire

// File: rtl/iob_sync_pack_fifo_lane_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iob_pack_lane_reg : lane counter and partial-word registers; emits push
// strobe and assembled wide word (partial flush merge included).  Rev 1.0
// ----------------------------------------------------------------------------
module iob_pack_lane_reg
  import iob_pack_fifo_pkg::*;
#(
  parameter int W_DATA_W = W_DATA_W_DEF,
  parameter int N_LANES  = RATIO,
  parameter int LN_W     = $clog2(N_LANES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        write_int,
  input  logic                        flush_ok,
  input  logic [W_DATA_W-1:0]         data_in,
  output logic [LN_W-1:0]             lane,
  output logic                        push,
  output logic [N_LANES*W_DATA_W-1:0] word
);

  logic [LN_W-1:0]     lane_q, lane_d;
  logic [W_DATA_W-1:0] lanes_q [N_LANES-1];
  logic [W_DATA_W-1:0] lanes_d [N_LANES-1];
  logic                last_lane;

  assign last_lane = (lane_q == LN_W'(N_LANES - 1));
  // A flush only pushes when there is something to push: stored lanes or the current write.
  assign push      = (write_int & last_lane) | (flush_ok & (write_int | (lane_q != '0)));
  assign lane      = lane_q;

  always_comb begin
    lane_d  = lane_q;
    lanes_d = lanes_q;
    if (push) begin
      lane_d = '0;
    end else if (write_int) begin
      lane_d = lane_q + LN_W'(1);
      for (int k = 0; k < N_LANES - 1; k++) begin
        if (lane_q == LN_W'(k)) lanes_d[k] = data_in;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      for (int k = 0; k < N_LANES - 1; k++) lanes_q[k] <= '0;
    end else begin
      lane_q  <= lane_d;
      lanes_q <= lanes_d;
    end
  end

  // Lanes below the counter come from storage, the current lane from data_in, the rest are zero.
  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic sel_in;
    assign sel_in = write_int & (lane_q == LN_W'(k));
    if (k < N_LANES - 1) begin : g_stored
      assign word[k*W_DATA_W +: W_DATA_W] = (lane_q > LN_W'(k)) ? lanes_q[k] :
                                            (sel_in ? data_in : '0);
    end else begin : g_top
      assign word[k*W_DATA_W +: W_DATA_W] = sel_in ? data_in : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/iob_sync_pack_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// iob_sync_pack_fifo : narrow-write / wide-read synchronous packing FIFO
// Optional partial-word flush with IOB_PACK_FIFO_FLUSH_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module iob_sync_pack_fifo
  import iob_pack_fifo_pkg::*;
#(
  parameter int W_DATA_W = W_DATA_W_DEF,
  parameter int R_DATA_W = R_DATA_W_DEF,
  parameter int R_ADDR_W = R_ADDR_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  iob_sync_pack_fifo_if.slave  bus
);

  localparam int N_LANES = R_DATA_W / W_DATA_W;
  localparam int LN_W    = $clog2(N_LANES);
  localparam int N_WORDS = 2 ** R_ADDR_W;
  localparam int OCC_W   = R_ADDR_W + 1;

  if ((R_DATA_W % W_DATA_W) != 0 || !is_pow2(N_LANES)) begin : g_bad_cfg
    $error("iob_sync_pack_fifo: R_DATA_W must be a power-of-two multiple (>=2) of W_DATA_W");
  end

  logic [R_ADDR_W-1:0] wptr_q, wptr_d;
  logic [R_ADDR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [R_DATA_W-1:0] data_out_q, data_out_d;
  logic [R_DATA_W-1:0] mem [N_WORDS];

  logic                full, empty, write_int, read_int, flush_ok, push, occ_full;
  logic [LN_W-1:0]     lane;
  logic [R_DATA_W-1:0] word;

  assign occ_full  = (occ_q == OCC_W'(N_WORDS));
  // Lanes keep filling while storage is full; only the completing write is refused.
  assign full      = occ_full & (lane == LN_W'(N_LANES - 1));
  assign empty     = (occ_q == '0);
  assign write_int = bus.write_en & ~full;
  assign read_int  = bus.read_en & ~empty;

`ifdef IOB_PACK_FIFO_FLUSH_EN
  assign flush_ok = bus.flush & ~occ_full;
`else
  assign flush_ok = 1'b0;
`endif

  iob_pack_lane_reg #(
    .W_DATA_W (W_DATA_W),
    .N_LANES  (N_LANES),
    .LN_W     (LN_W)
  ) u_lane_reg (
    .clk       (clk),
    .rst       (rst),
    .write_int (write_int),
    .flush_ok  (flush_ok),
    .data_in   (bus.data_in),
    .lane      (lane),
    .push      (push),
    .word      (word)
  );

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    data_out_d = data_out_q;
    if (push) wptr_d = wptr_q + R_ADDR_W'(1);
    if (read_int) begin
      rptr_d     = rptr_q + R_ADDR_W'(1);
      data_out_d = mem[rptr_q];
    end
    if (push && !read_int) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push && read_int) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      data_out_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage array is intentionally left without reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= word;
  end

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.data_out = data_out_q;
  assign bus.level    = {occ_q, lane};

endmodule
`default_nettype wire
